interp_stream_out: RTL and testbench
====================================

INTERP_STREAM_OUT -- requirements
Module: interp_stream_out

Interface
REQ-001 SHALL provide parameter INW, default 28, sample width; matches the width of the upstream interpolator output.
REQ-002 SHALL provide parameter LGFIFO, default 4, log2 of buffer capacity (DEPTH = 2^LGFIFO samples), legal range 1..10.
REQ-003 SHALL provide ports, clock and reset first:
  i_clk  in  1  sole clock
  i_areset_n  in  1  asynchronous active-low reset
  i_ce  in  1  upstream interpolator output strobe, one sample per high cycle
  i_data  in  INW  upstream interpolated sample, valid when i_ce=1
  o_valid  out  1  output stream valid
  i_ready  in  1  downstream ready
  o_data  out  INW  output stream sample
  o_fill  out  LGFIFO+1  samples currently held, 0..DEPTH
  o_overflow  out  1  sticky flag: a sample was dropped
  i_clr_overflow  in  1  clears o_overflow (and o_ovcount when present)
  o_ovcount  out  16  dropped-sample count; present only with INTERP_OVCOUNT_EN

Function
REQ-004 SHALL buffer strobed samples from i_ce/i_data and present them in arrival order on a valid/ready stream.
REQ-005 SHALL accept a sample on every cycle with i_ce=1, unless it is dropped per REQ-010.
REQ-006 SHALL treat a transfer as occurring on a rising edge with o_valid=1 and i_ready=1; o_data SHALL then advance to the next sample or o_valid SHALL fall.
REQ-007 SHALL hold o_data and o_valid stable while o_valid=1 and i_ready=0.
REQ-008 SHALL have latency of one cycle: a sample written into an empty buffer at edge n drives o_valid=1 and o_data=sample after edge n.
REQ-009 SHALL keep o_fill = accepted minus transferred; a simultaneous write and transfer leaves o_fill unchanged.
REQ-010 SHALL accept the sample when o_fill=DEPTH, i_ce=1 and a transfer occurs on the same edge; when full with no transfer, it SHALL drop the new sample, leave the stored samples untouched and set o_overflow.
REQ-011 SHALL keep o_overflow set until an edge with i_clr_overflow=1 and no concurrent drop; a drop on the same edge as a clear SHALL leave o_overflow=1.
REQ-012 SHALL let read and write pointers wrap modulo DEPTH, with no loss or duplication across the wrap.
REQ-013 SHALL ignore i_ready when o_valid=0 (no pointer movement, no underflow).

Reset
REQ-014 SHALL, on i_areset_n low, immediately and asynchronously set o_valid=0, o_data=0, o_fill=0, o_overflow=0, o_ovcount=0 and both pointers to 0.
REQ-015 SHALL discard all buffered samples on reset asserted mid-stream; storage contents need not be reset.
REQ-016 SHALL ignore i_ce on the first edge after reset deassertion only if a synchronizer is used; otherwise it SHALL accept from the first edge. The chosen behaviour SHALL be stated in the implementation header.

Configuration
REQ-017 SHALL, with INTERP_OVCOUNT_EN defined, count dropped samples in o_ovcount, saturating at 16'hFFFF, cleared by i_clr_overflow; a drop on the same edge as a clear SHALL yield o_ovcount=1.
REQ-018 SHALL, without INTERP_OVCOUNT_EN, omit port o_ovcount and its counter; all other behaviour identical.

Structure
REQ-019 SHALL take the INW and LGFIFO defaults and the overflow counter width (16) from shared package interp_pkg.
REQ-020 SHALL place storage and pointers in sub-module interp_sfifo; the top level holds the output register, overflow logic and counter.

Verification
REQ-021 Reset, then i_ce pulse with i_data=28'h0ABCDEF, i_ready=0 -> next cycle o_valid=1, o_data=28'h0ABCDEF, o_fill=1.
REQ-022 LGFIFO=4, write 0..15 with i_ready=0, then write 16 -> o_fill=16, o_overflow=1, o_ovcount=1 (macro on); drain reads 0..15 in order and 16 never appears.
REQ-023 Full buffer, i_ce=1 and i_ready=1 on the same cycle with data 99 -> o_fill stays 16, no overflow, 99 appears after the remaining 15.
REQ-024 Continuous i_ce with i_ready=1 for 100 samples -> output sequence equals input sequence, o_fill stays at most 1, pointers wrap six times cleanly.
REQ-025 Drop and i_clr_overflow on the same edge -> o_overflow=1, o_ovcount=1; clear alone next cycle -> both 0.
REQ-026 i_areset_n low mid-stream with o_fill=7 -> o_valid, o_fill and o_data become 0 immediately; the first sample after release is the first one output.

Source files
------------

// File: rtl/interp_pkg.sv
// ---------------------------------------------------------------------------
// interp_pkg
//
// Shared definitions for the interpolator output stream block:
//   INTERP_INW     default sample width (matches the interpolator output)
//   INTERP_LGFIFO  default log2 of the sample buffer depth
//   OVCNT_W        width of the optional dropped-sample counter
//   ovcnt_sat_inc  saturating increment used by that counter
// ---------------------------------------------------------------------------
package interp_pkg;

    localparam int INTERP_INW    = 28;
    localparam int INTERP_LGFIFO = 4;
    localparam int OVCNT_W       = 16;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [OVCNT_W-1:0] ovcnt_sat_inc(input logic [OVCNT_W-1:0] cnt);
        return (cnt == {OVCNT_W{1'b1}}) ? cnt : cnt + OVCNT_W'(1);
    endfunction

endpackage : interp_pkg

// File: rtl/interp_sfifo.sv
// ---------------------------------------------------------------------------
// interp_sfifo
//
// Sample storage and pointers for interp_stream_out. A DEPTH = 2^LGFIFO entry
// circular buffer with a full-range occupancy count. The caller guarantees it
// never writes when full without reading on the same edge, and never reads
// when empty.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset (pointers and count only)
//   wr_i         write wr_data_i at the tail this edge
//   wr_data_i    sample to store
//   rd_i         retire the head entry this edge
//   fill_o       entries currently held, 0..DEPTH
//   next_data_o  entry one past the head (the new head after a read)
// ---------------------------------------------------------------------------
module interp_sfifo
    import interp_pkg::*;
#(
    parameter int INW    = INTERP_INW,
    parameter int LGFIFO = INTERP_LGFIFO
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  logic [INW-1:0]    wr_data_i,
    input  logic              rd_i,
    output logic [LGFIFO:0]   fill_o,
    output logic [INW-1:0]    next_data_o
);

    localparam int DEPTH = 1 << LGFIFO;
    localparam logic [LGFIFO-1:0] PTR_ONE = LGFIFO'(1);
    localparam logic [LGFIFO:0]   CNT_ONE = (LGFIFO + 1)'(1);

    logic [INW-1:0]    mem_q [0:DEPTH-1];
    logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFIFO-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFIFO:0]   fill_q,   fill_d;

    // Pointers are exactly LGFIFO bits wide, so wrapping modulo DEPTH is free.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (wr_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_i) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_i, rd_i})
            2'b10:   fill_d = fill_q + CNT_ONE;
            2'b01:   fill_d = fill_q - CNT_ONE;
            default: fill_d = fill_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // NOTE: the sample array has no reset; clearing the pointers and count is
    // what discards its contents, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign fill_o      = fill_q;
    assign next_data_o = mem_q[rd_ptr_q + PTR_ONE];

endmodule : interp_sfifo

// File: rtl/interp_stream_out.sv
// ---------------------------------------------------------------------------
// interp_stream_out
//
// Turns the strobed output of an interpolator (i_ce/i_data) into a valid/ready
// stream. Samples are buffered in arrival order in interp_sfifo; the head
// sample is held in a registered output stage so o_data/o_valid come straight
// from flops. A sample arriving while the buffer is full and no transfer takes
// place is dropped and flagged on the sticky o_overflow.
//
// There is no reset synchronizer: i_ce is accepted from the very first edge
// after i_areset_n is released.
//
// Build option: define INTERP_OVCOUNT_EN to add the 16-bit saturating
// dropped-sample counter and its o_ovcount port.
//
// Ports:
//   i_clk           clock
//   i_areset_n      asynchronous active-low reset
//   i_ce            upstream sample strobe
//   i_data          upstream sample, valid when i_ce=1
//   o_valid         output stream valid
//   i_ready         downstream ready
//   o_data          output stream sample
//   o_fill          samples held, 0..2^LGFIFO (includes the one on o_data)
//   o_overflow      sticky: at least one sample was dropped
//   i_clr_overflow  clears o_overflow (and o_ovcount)
//   o_ovcount       dropped-sample count (INTERP_OVCOUNT_EN only)
// ---------------------------------------------------------------------------
module interp_stream_out
    import interp_pkg::*;
#(
    parameter int INW    = INTERP_INW,
    parameter int LGFIFO = INTERP_LGFIFO
) (
    input  logic               i_clk,
    input  logic               i_areset_n,
    input  logic               i_ce,
    input  logic [INW-1:0]     i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [INW-1:0]     o_data,
    output logic [LGFIFO:0]    o_fill,
    output logic               o_overflow,
    input  logic               i_clr_overflow
`ifdef INTERP_OVCOUNT_EN
    ,
    output logic [OVCNT_W-1:0] o_ovcount
`endif
);

    localparam logic [LGFIFO:0] CNT_ONE = (LGFIFO + 1)'(1);

    logic [LGFIFO:0] fill;
    logic [INW-1:0]  next_head;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    logic            valid_q, valid_d;
    logic [INW-1:0]  data_q,  data_d;
    logic            ovf_q,   ovf_d;

    // fill never exceeds DEPTH, so its MSB alone marks a full buffer.
    assign empty = (fill == '0);
    assign full  = fill[LGFIFO];

    // A transfer frees a slot on the same edge, so a full buffer still accepts.
    assign pop  = valid_q & i_ready;
    assign push = i_ce & (~full | pop);
    assign drop = i_ce & ~push;

    interp_sfifo #(
        .INW    (INW),
        .LGFIFO (LGFIFO)
    ) u_sfifo (
        .clk_i       (i_clk),
        .rst_ni      (i_areset_n),
        .wr_i        (push),
        .wr_data_i   (i_data),
        .rd_i        (pop),
        .fill_o      (fill),
        .next_data_o (next_head)
    );

    // The output register mirrors the buffer head. When the head is retired,
    // the new head is either the next stored entry or, if this was the last
    // entry, the sample being written on the same edge (not yet in storage).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (pop) begin
            if (fill == CNT_ONE) begin
                valid_d = push;
                if (push) begin
                    data_d = i_data;
                end
            end else begin
                data_d = next_head;
            end
        end else if (empty && push) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end
    end

    // A drop always wins over a clear on the same edge.
    assign ovf_d = drop | (ovf_q & ~i_clr_overflow);

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_fill     = fill;
    assign o_overflow = ovf_q;

`ifdef INTERP_OVCOUNT_EN
    logic [OVCNT_W-1:0] ovc_q, ovc_d;

    // A clear restarts the count; a drop on that same edge counts as the first.
    always_comb begin
        ovc_d = ovc_q;
        if (i_clr_overflow) begin
            ovc_d = drop ? OVCNT_W'(1) : '0;
        end else if (drop) begin
            ovc_d = ovcnt_sat_inc(ovc_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            ovc_q <= '0;
        end else begin
            ovc_q <= ovc_d;
        end
    end

    assign o_ovcount = ovc_q;
`endif

endmodule : interp_stream_out

// File: tb/tb_interp_stream_out.sv
module tb_interp_stream_out;

    localparam int INW    = 28;
    localparam int LGFIFO = 4;
    localparam int DEPTH  = 1 << LGFIFO;

    logic              i_clk = 1'b0;
    logic              i_areset_n = 1'b0;
    logic              i_ce = 1'b0;
    logic [INW-1:0]    i_data = '0;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [INW-1:0]    o_data;
    logic [LGFIFO:0]   o_fill;
    logic              o_overflow;
    logic              i_clr_overflow = 1'b0;
`ifdef INTERP_OVCOUNT_EN
    logic [15:0]       o_ovcount;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain queue of held samples plus the overflow state.
    logic [INW-1:0] mq [$];
    bit             m_ovf;
    int unsigned    m_ovc;

    interp_stream_out #(
        .INW    (INW),
        .LGFIFO (LGFIFO)
    ) dut (
        .i_clk          (i_clk),
        .i_areset_n     (i_areset_n),
        .i_ce           (i_ce),
        .i_data         (i_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_fill         (o_fill),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow)
`ifdef INTERP_OVCOUNT_EN
        ,
        .o_ovcount      (o_ovcount)
`endif
    );

    initial forever #5 i_clk = ~i_clk;

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_ovc = 0;
    endtask

    function automatic logic [INW-1:0] m_head();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model with
    // the same inputs, then settle 1 time unit past the edge for sampling.
    task automatic cycle(input logic ce, input logic [INW-1:0] d,
                         input logic rdy, input logic clr);
        bit pop, push, drop;
        i_ce = ce; i_data = d; i_ready = rdy; i_clr_overflow = clr;
        @(posedge i_clk);
        pop  = (mq.size() > 0) && rdy;
        push = ce && ((mq.size() < DEPTH) || pop);
        drop = ce && !push;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_ovc = drop ? 1 : 0;
        else if (drop && m_ovc < 65535) m_ovc++;
        #1;
    endtask

    // Pulse reset between edges and return with it released.
    task automatic do_reset();
        i_ce = 0; i_ready = 0; i_clr_overflow = 0;
        i_areset_n = 1'b0;
        model_reset();
        #2;
        i_areset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        model_reset();
        checks++;
        if (o_valid !== 1'b0 || o_fill !== '0 || o_data !== '0 || o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: valid=%b fill=%0d data=%h ovf=%b, want all 0",
                     o_valid, o_fill, o_data, o_overflow);
        end
`ifdef INTERP_OVCOUNT_EN
        checks++;
        if (o_ovcount !== 16'd0) begin
            failures++;
            $display("FAIL reset_ovcount: got %0d want 0", o_ovcount);
        end
`endif
        i_areset_n = 1'b1;
        cycle(0, '0, 1, 0);
        checks++;
        if (o_valid !== 1'b0 || o_fill !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: valid=%b fill=%0d want 0/0", o_valid, o_fill);
        end
    endtask

    task automatic test_first_sample();
        do_reset();
        cycle(1, 28'h0ABCDEF, 0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 28'h0ABCDEF || o_fill !== 5'd1) begin
            failures++;
            $display("FAIL first_sample: valid=%b data=%h fill=%0d want 1/0abcdef/1",
                     o_valid, o_data, o_fill);
        end
        // Held stable while not ready.
        cycle(0, '0, 0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 28'h0ABCDEF || o_fill !== 5'd1) begin
            failures++;
            $display("FAIL hold_stall: valid=%b data=%h fill=%0d want 1/0abcdef/1",
                     o_valid, o_data, o_fill);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, INW'(i), 0, 0);
        checks++;
        if (o_fill !== 5'd16 || o_overflow !== 1'b0 || o_data !== '0) begin
            failures++;
            $display("FAIL full_no_ovf: fill=%0d ovf=%b data=%h want 16/0/0", o_fill, o_overflow, o_data);
        end
        cycle(1, INW'(16), 0, 0);
        checks++;
        if (o_fill !== 5'd16 || o_overflow !== 1'b1) begin
            failures++;
            $display("FAIL drop_when_full: fill=%0d ovf=%b want 16/1", o_fill, o_overflow);
        end
`ifdef INTERP_OVCOUNT_EN
        checks++;
        if (o_ovcount !== 16'd1) begin
            failures++;
            $display("FAIL drop_count: got %0d want 1", o_ovcount);
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== INW'(i)) begin
                failures++;
                $display("FAIL drain_order[%0d]: valid=%b data=%0d want 1/%0d", i, o_valid, o_data, i);
            end
            cycle(0, '0, 1, 0);
        end
        checks++;
        if (o_valid !== 1'b0 || o_fill !== '0 || o_overflow !== 1'b1) begin
            failures++;
            $display("FAIL drained: valid=%b fill=%0d ovf=%b want 0/0/1", o_valid, o_fill, o_overflow);
        end
        // Ready while empty must not move anything.
        cycle(0, '0, 1, 0);
        checks++;
        if (o_valid !== 1'b0 || o_fill !== '0) begin
            failures++;
            $display("FAIL empty_ready: valid=%b fill=%0d want 0/0", o_valid, o_fill);
        end
    endtask

    task automatic test_full_passthrough();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, INW'(100 + i), 0, 0);
        cycle(1, INW'(99), 1, 0);
        checks++;
        if (o_fill !== 5'd16 || o_overflow !== 1'b0 || o_data !== INW'(101)) begin
            failures++;
            $display("FAIL full_rw: fill=%0d ovf=%b data=%0d want 16/0/101", o_fill, o_overflow, o_data);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            logic [INW-1:0] want;
            want = (i < DEPTH) ? INW'(100 + i) : INW'(99);
            checks++;
            if (o_valid !== 1'b1 || o_data !== want) begin
                failures++;
                $display("FAIL full_rw_order[%0d]: valid=%b data=%0d want 1/%0d", i, o_valid, o_data, want);
            end
            cycle(0, '0, 1, 0);
        end
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_rw_empty: valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [INW-1:0] sent [$];
        logic [INW-1:0] got  [$];
        int max_fill = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            logic [INW-1:0] d;
            d = INW'($urandom);
            if (o_valid) got.push_back(o_data);
            cycle(1, d, 1, 0);
            sent.push_back(d);
            if (int'(o_fill) > max_fill) max_fill = int'(o_fill);
        end
        for (int i = 0; i < 4; i++) begin
            if (o_valid) got.push_back(o_data);
            cycle(0, '0, 1, 0);
        end
        checks++;
        if (max_fill > 1) begin
            failures++;
            $display("FAIL stream_fill: max fill %0d want <=1", max_fill);
        end
        checks++;
        if (got.size() != sent.size()) begin
            failures++;
            $display("FAIL stream_count: got %0d samples want %0d", got.size(), sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    failures++;
                    $display("FAIL stream_data[%0d]: got %h want %h", i, got[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_clear_race();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, INW'(i), 0, 0);
        cycle(1, INW'(500), 0, 0);
        cycle(1, INW'(501), 0, 0);
        cycle(1, INW'(502), 0, 1);
        checks++;
        if (o_overflow !== 1'b1 || o_fill !== 5'd16) begin
            failures++;
            $display("FAIL clr_race: ovf=%b fill=%0d want 1/16", o_overflow, o_fill);
        end
`ifdef INTERP_OVCOUNT_EN
        checks++;
        if (o_ovcount !== 16'd1) begin
            failures++;
            $display("FAIL clr_race_count: got %0d want 1", o_ovcount);
        end
`endif
        cycle(0, '0, 0, 1);
        checks++;
        if (o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL clr_alone: ovf=%b want 0", o_overflow);
        end
`ifdef INTERP_OVCOUNT_EN
        checks++;
        if (o_ovcount !== 16'd0) begin
            failures++;
            $display("FAIL clr_alone_count: got %0d want 0", o_ovcount);
        end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1, INW'(700 + i), 0, 0);
        checks++;
        if (o_fill !== 5'd7) begin
            failures++;
            $display("FAIL pre_reset_fill: got %0d want 7", o_fill);
        end
        i_areset_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_fill !== '0 || o_data !== '0) begin
            failures++;
            $display("FAIL async_reset: valid=%b fill=%0d data=%h want 0/0/0", o_valid, o_fill, o_data);
        end
        model_reset();
        #1;
        i_areset_n = 1'b1;
        cycle(1, INW'(28'h5A5A5A5), 0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 28'h5A5A5A5 || o_fill !== 5'd1) begin
            failures++;
            $display("FAIL post_reset_first: valid=%b data=%h fill=%0d want 1/5a5a5a5/1",
                     o_valid, o_data, o_fill);
        end
        cycle(0, '0, 1, 0);
        checks++;
        if (o_valid !== 1'b0 || o_fill !== '0) begin
            failures++;
            $display("FAIL post_reset_drain: valid=%b fill=%0d want 0/0", o_valid, o_fill);
        end
    endtask

    task automatic test_random();
        int rdy_pct;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rdy_pct = ((c / 60) % 2 == 0) ? 25 : 85;
            cycle($urandom_range(0, 99) < 65, INW'($urandom),
                  $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < 4);
            checks++;
            if (o_valid !== (mq.size() > 0) || o_fill !== (LGFIFO + 1)'(mq.size())) begin
                failures++;
                $display("FAIL rand_occupancy@%0d: valid=%b fill=%0d want %b/%0d",
                         c, o_valid, o_fill, mq.size() > 0, mq.size());
            end
            if (mq.size() > 0) begin
                checks++;
                if (o_data !== m_head()) begin
                    failures++;
                    $display("FAIL rand_data@%0d: got %h want %h", c, o_data, m_head());
                end
            end
            checks++;
            if (o_overflow !== m_ovf) begin
                failures++;
                $display("FAIL rand_ovf@%0d: got %b want %b", c, o_overflow, m_ovf);
            end
`ifdef INTERP_OVCOUNT_EN
            checks++;
            if (o_ovcount !== 16'(m_ovc)) begin
                failures++;
                $display("FAIL rand_ovcount@%0d: got %0d want %0d", c, o_ovcount, m_ovc);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_overflow();
        test_full_passthrough();
        test_back_to_back();
        test_clear_race();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_interp_stream_out
